toggle_cover_source: RTL and testbench

- Producer end of the toggle-coverage valid-vector interface.
- Samples a WIDTH-bit monitored signal and tracks rising and falling edges per bit.
- Emits a one-cycle valid pulse per bit on its first full toggle (0->1 and 1->0 both seen); this drives the sink's valid vector.
- Also drains newly covered global indices through a valid/ready stream so synthesizable targets can export coverage without DPI.

---
 rtl/toggle_cover_pkg.sv | 26 ++
 rtl/toggle_cover_lsb_enc.sv | 28 ++
 rtl/toggle_cover_source.sv | 169 ++++++++++++++++
 tb/tb_toggle_cover_source.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_cover_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toggle_cover_pkg
// Purpose  : Shared types, constants and helpers for the toggle-cover source.
// Revision : 1.0
// ============================================================================
package toggle_cover_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsm_state_t;

    localparam int IDX_W_DEFAULT = 32;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_cover_lsb_enc.sv
`default_nettype none
// ============================================================================
// Module   : toggle_cover_lsb_enc
// Purpose  : Combinational lowest-set-bit finder with an any-bit-set flag.
// Revision : 1.0
// ============================================================================
module toggle_cover_lsb_enc #(
    parameter int WIDTH = 32,
    parameter int ENC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [ENC_W-1:0] index,
    output logic             any_set
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        index   = '0;
        any_set = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = ENC_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/toggle_cover_source.sv
`default_nettype none
// ============================================================================
// Module   : toggle_cover_source
// Purpose  : Per-bit toggle coverage producer: valid pulses plus index stream.
//            Define TOGGLE_COVER_REPEAT_EN to pulse valid on every toggle pair.
// Revision : 1.0
// ============================================================================
module toggle_cover_source
    import toggle_cover_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int COVER_INDEX = 0,
    parameter int IDX_W       = IDX_W_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           sig,
    output logic [WIDTH-1:0]           valid,
    output logic                       idx_valid,
    input  logic                       idx_ready,
    output logic [IDX_W-1:0]           idx_data,
    output logic [$clog2(WIDTH+1)-1:0] covered_cnt
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int ENC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("toggle_cover_source: WIDTH must be in 1..64");
    end

    if (IDX_W < 64 &&
        (64'(COVER_INDEX) + 64'(WIDTH) - 64'd1) >= (64'd1 << IDX_W)) begin : g_idx_check
        $error("toggle_cover_source: COVER_INDEX+WIDTH-1 does not fit in IDX_W");
    end

    logic [WIDTH-1:0] r_prev, r_rise_seen, r_fall_seen, r_covered, r_pending, r_valid;
    logic [CNT_W-1:0] r_covered_cnt;
    logic [IDX_W-1:0] r_idx_data;
    logic             r_armed;
    fsm_state_t       r_state, w_state_next;

    logic             w_sample;
    logic [WIDTH-1:0] w_rs_nx, w_fs_nx, w_pair, w_newcov, w_pulse, w_rs_upd, w_fs_upd;
    logic [63:0]      w_newcov64;
    logic [6:0]       w_pc;
    logic [CNT_W-1:0] w_newcnt;
    logic [ENC_W-1:0] w_enc_idx;
    logic             w_any;
    logic             w_load;
    logic [WIDTH-1:0] w_pend_clr;

    assign w_sample = en & r_armed & ~clear;

    always_comb begin
        w_rs_nx = r_rise_seen;
        w_fs_nx = r_fall_seen;
        if (w_sample) begin
            w_rs_nx = r_rise_seen | (sig & ~r_prev);
            w_fs_nx = r_fall_seen | (~sig & r_prev);
        end
        w_pair   = w_rs_nx & w_fs_nx;
        w_newcov = w_sample ? (w_pair & ~r_covered) : '0;
`ifdef TOGGLE_COVER_REPEAT_EN
        // Completed pairs re-arm immediately so each later pair pulses again.
        w_pulse  = w_sample ? w_pair : '0;
        w_rs_upd = w_rs_nx & ~w_pair;
        w_fs_upd = w_fs_nx & ~w_pair;
`else
        w_pulse  = w_newcov;
        w_rs_upd = w_rs_nx;
        w_fs_upd = w_fs_nx;
`endif
        w_newcov64             = '0;
        w_newcov64[WIDTH-1:0]  = w_newcov;
        w_pc                   = popcount(w_newcov64);
        w_newcnt               = CNT_W'(w_pc);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev        <= '0;
            r_rise_seen   <= '0;
            r_fall_seen   <= '0;
            r_covered     <= '0;
            r_pending     <= '0;
            r_valid       <= '0;
            r_covered_cnt <= '0;
            r_armed       <= 1'b0;
        end else if (clear) begin
            r_rise_seen   <= '0;
            r_fall_seen   <= '0;
            r_covered     <= '0;
            r_pending     <= '0;
            r_valid       <= '0;
            r_covered_cnt <= '0;
            r_armed       <= 1'b0;
        end else begin
            if (en) begin
                r_prev  <= sig;
                r_armed <= 1'b1;
            end
            r_rise_seen   <= w_rs_upd;
            r_fall_seen   <= w_fs_upd;
            r_covered     <= r_covered | w_newcov;
            r_pending     <= (r_pending & ~w_pend_clr) | w_newcov;
            r_valid       <= w_pulse;
            r_covered_cnt <= r_covered_cnt + w_newcnt;
        end
    end

    // Encoder sees registered pending only, so same-cycle arrivals wait a cycle.
    toggle_cover_lsb_enc #(
        .WIDTH (WIDTH),
        .ENC_W (ENC_W)
    ) u_lsb_enc (
        .vec     (r_pending),
        .index   (w_enc_idx),
        .any_set (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && !clear) begin
                    w_load       = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (idx_ready) begin
                    if (w_any && !clear) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        w_pend_clr = '0;
        if (w_load) begin
            w_pend_clr[w_enc_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_idx_data <= IDX_W'(COVER_INDEX) + IDX_W'(w_enc_idx);
            end
        end
    end

    assign valid       = r_valid;
    assign idx_valid   = (r_state == SEND);
    assign idx_data    = r_idx_data;
    assign covered_cnt = r_covered_cnt;

endmodule
`default_nettype wire

// File: tb/tb_toggle_cover_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_cover_source
// Purpose  : Scoreboard bench for toggle_cover_source (WIDTH=32, COVER_INDEX=5).
// Revision : 1.0
// ============================================================================
module tb_toggle_cover_source;

    localparam int WIDTH       = 32;
    localparam int COVER_INDEX = 5;
    localparam int IDX_W       = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    logic              clear = 1'b0;
    logic              idx_ready = 1'b0;
    logic [WIDTH-1:0]  sig = '0;
    logic [WIDTH-1:0]  valid;
    logic              idx_valid;
    logic [IDX_W-1:0]  idx_data;
    logic [5:0]        covered_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_valid_q[$];
    logic [31:0] exp_idx_q[$];
    logic [31:0] mon_exp_v;
    logic [31:0] mon_exp_i;

    toggle_cover_source #(
        .WIDTH       (WIDTH),
        .COVER_INDEX (COVER_INDEX),
        .IDX_W       (IDX_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .clear       (clear),
        .sig         (sig),
        .valid       (valid),
        .idx_valid   (idx_valid),
        .idx_ready   (idx_ready),
        .idx_data    (idx_data),
        .covered_cnt (covered_cnt)
    );

    always #5 clock = ~clock;

    // Monitor: every valid pulse and every index handshake must match the queue head.
    always @(negedge clock) begin
        if (reset) begin
            if (valid != '0) begin
                checks++;
                if (exp_valid_q.size() == 0) begin
                    errors++;
                    $display("FAIL valid_pulse: got %h, required no pulse", valid);
                end else begin
                    mon_exp_v = exp_valid_q.pop_front();
                    if (valid !== mon_exp_v) begin
                        errors++;
                        $display("FAIL valid_pulse: got %h, required %h", valid, mon_exp_v);
                    end
                end
            end
            if (idx_valid && idx_ready) begin
                checks++;
                if (exp_idx_q.size() == 0) begin
                    errors++;
                    $display("FAIL idx_beat: got %0d, required no beat", idx_data);
                end else begin
                    mon_exp_i = exp_idx_q.pop_front();
                    if (idx_data !== mon_exp_i) begin
                        errors++;
                        $display("FAIL idx_beat: got %0d, required %0d", idx_data, mon_exp_i);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_valid_q.size() != 0 || exp_idx_q.size() != 0) && n < 100) begin
            step();
            n++;
        end
        check(name, 64'(exp_valid_q.size() + exp_idx_q.size()), 64'd0);
    endtask

    task automatic push_all_idx();
        for (int b = 0; b < WIDTH; b++) exp_idx_q.push_back(32'(COVER_INDEX + b));
    endtask

    task automatic clear_cycle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int first_c;
        int last_c;
        int bad;
        int n;

        // Reset state
        idx_ready = 1'b1;
        #12;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_idx_valid", 64'(idx_valid), 64'd0);
        check("rst_idx_data", 64'(idx_data), 64'd0);
        check("rst_cnt", 64'(covered_cnt), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single bit 0 -> 1 -> 0
        en  = 1'b1;
        sig = 32'h0;
        step();
        sig = 32'h1;
        step();
        exp_valid_q.push_back(32'h1);
        exp_idx_q.push_back(32'd5);
        sig = 32'h0;
        step();
        steps(4);
        check("t1_cnt", 64'(covered_cnt), 64'd1);
        drain("t1_drain");

        // All bits, back-to-back drain
        clear_cycle();
        sig = 32'h0;
        step();
        sig = 32'hFFFF_FFFF;
        step();
        exp_valid_q.push_back(32'hFFFF_FFFF);
        push_all_idx();
        sig = 32'h0;
        step();
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 40; c++) begin
            if (idx_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            step();
        end
        check("t2_burst_len", 64'(last_c - first_c + 1), 64'd32);
        check("t2_cnt", 64'(covered_cnt), 64'd32);
        drain("t2_drain");

        // Same with a 10-cycle stall
        clear_cycle();
        sig = 32'h0;
        step();
        sig = 32'hFFFF_FFFF;
        step();
        idx_ready = 1'b0;
        exp_valid_q.push_back(32'hFFFF_FFFF);
        push_all_idx();
        sig = 32'h0;
        step();
        step();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!idx_valid || idx_data !== 32'(COVER_INDEX)) bad++;
            step();
        end
        check("t3_stall_hold", 64'(bad), 64'd0);
        idx_ready = 1'b1;
        drain("t3_drain");
        check("t3_cnt", 64'(covered_cnt), 64'd32);

        // Re-toggle an already covered bit
        for (int p = 0; p < 2; p++) begin
            sig = 32'h8;
            step();
`ifdef TOGGLE_COVER_REPEAT_EN
            exp_valid_q.push_back(32'h8);
`endif
            sig = 32'h0;
            step();
        end
        steps(4);
        drain("t4_drain");
        check("t4_cnt", 64'(covered_cnt), 64'd32);
        check("t4_no_idx", 64'(idx_valid), 64'd0);

        // Clear while index 7 is in flight, pending 8 and 9
        clear_cycle();
        idx_ready = 1'b0;
        sig = 32'h0;
        step();
        sig = 32'h1C;
        step();
        exp_valid_q.push_back(32'h1C);
        exp_idx_q.push_back(32'd7);
        sig = 32'h0;
        step();
        steps(3);
        check("t5_hold_idx", 64'(idx_data), 64'd7);
        clear_cycle();
        check("t5_cnt_cleared", 64'(covered_cnt), 64'd0);
        check("t5_beat_kept", 64'(idx_valid), 64'd1);
        idx_ready = 1'b1;
        sig = 32'h1;
        step();
        sig = 32'h0;
        step();
        steps(3);
        check("t5_idle", 64'(idx_valid), 64'd0);
        exp_valid_q.push_back(32'h1);
        exp_idx_q.push_back(32'd5);
        sig = 32'h1;
        step();
        steps(4);
        drain("t5_drain");
        check("t5_cnt", 64'(covered_cnt), 64'd1);

        // Asynchronous reset in the middle of SEND
        idx_ready = 1'b0;
        sig = 32'h21;
        step();
        exp_valid_q.push_back(32'h20);
        sig = 32'h01;
        step();
        n = 0;
        while (!idx_valid && n < 10) begin
            step();
            n++;
        end
        check("t6_send_idx", 64'(idx_data), 64'd10);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_idx_valid", 64'(idx_valid), 64'd0);
        check("t6_rst_idx_data", 64'(idx_data), 64'd0);
        check("t6_rst_valid", 64'(valid), 64'd0);
        check("t6_rst_cnt", 64'(covered_cnt), 64'd0);
        steps(2);
        reset = 1'b1;
        idx_ready = 1'b1;
        sig = 32'h1;
        step();
        sig = 32'h0;
        step();
        steps(3);
        exp_valid_q.push_back(32'h1);
        exp_idx_q.push_back(32'd5);
        sig = 32'h1;
        step();
        steps(4);
        drain("t6_drain");
        check("t6_cnt", 64'(covered_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
